// File: rtl/opcode_deserializer_pkg.sv
// Shared opcode definitions: op values, wire byte width, deserializer FSM states
// and the op validity rule.
package opcode_deserializer_pkg;

    localparam int BYTE_BITS = 8;

    typedef enum logic [BYTE_BITS-1:0] {
        OP_G00     = 8'd0,
        OP_G01     = 8'd1,
        OP_G02     = 8'd2,
        OP_G03     = 8'd3,
        OP_INVALID = 8'd255
    } opcode_t;

    typedef enum logic [1:0] {
        S_OP,
        S_ARG,
        S_FLAGS
    } state_t;

    function automatic logic is_valid_op(input logic [BYTE_BITS-1:0] op);
        return (op == OP_G00) || (op == OP_G01) || (op == OP_G02) || (op == OP_G03);
    endfunction

endpackage

// File: rtl/opcode_out_reg.sv
// Output holding register with valid/ready handshake for one assembled opcode word.
// can_load tells the producer a new word may be written this cycle without loss.
module opcode_out_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             can_load,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid
);

    assign can_load = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/opcode_deserializer.sv
// Assembles a byte stream (op, little-endian args, flags) into one opcode word,
// substituting OP_INVALID for unknown ops and counting such frames.
module opcode_deserializer
    import opcode_deserializer_pkg::*;
#(
    parameter int NUM_ARGS  = 4,
    parameter int ARG_BITS  = 12,
    parameter int OP_BITS   = 8,
    parameter int FLAG_BITS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         flush,
    output logic [OP_BITS-1:0]           out_op,
    output logic [NUM_ARGS*ARG_BITS-1:0] out_args,
    output logic [FLAG_BITS-1:0]         out_flags,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   err_count
);

    localparam int BPA       = (ARG_BITS + BYTE_BITS - 1) / BYTE_BITS;
    localparam int RAW_BITS  = NUM_ARGS * BPA * BYTE_BITS;
    localparam int ARGS_BITS = NUM_ARGS * ARG_BITS;
    localparam int WORD_BITS = OP_BITS + ARGS_BITS + FLAG_BITS;
    localparam int BIDX_W    = $clog2(BPA + 1);
    localparam int AIDX_W    = $clog2(NUM_ARGS + 1);
    localparam int POS_W     = $clog2(NUM_ARGS * BPA + 1);

    state_t               state;
    logic [BIDX_W-1:0]    byte_idx;
    logic [AIDX_W-1:0]    arg_idx;
    logic [OP_BITS-1:0]   op_q;
    logic [RAW_BITS-1:0]  raw_q;
    logic                 accept;
    logic                 load;
    logic                 can_load;
    logic                 op_ok;
    logic [POS_W-1:0]     pos;
    logic [ARGS_BITS-1:0] args_w;
    logic [OP_BITS-1:0]   op_w;
    logic [WORD_BITS-1:0] word_w;
    logic [WORD_BITS-1:0] word_q;

    // Gated by reset directly so the stream is stalled for the whole reset window.
    assign in_ready = reset && !flush && ((state != S_FLAGS) || can_load);
    assign accept   = in_valid && in_ready;
    assign load     = accept && (state == S_FLAGS);
    assign pos      = POS_W'(arg_idx) * POS_W'(BPA) + POS_W'(byte_idx);
    assign op_ok    = is_valid_op(op_q);
    assign op_w     = op_ok ? op_q : OP_BITS'(OP_INVALID);
    assign word_w   = {FLAG_BITS'(in_data), args_w, op_w};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        args_w = '0;
        for (int i = 0; i < NUM_ARGS; i++) begin
            args_w[i*ARG_BITS +: ARG_BITS] = raw_q[i*BPA*BYTE_BITS +: ARG_BITS];
        end
    end

    // NOTE: the partial-frame registers are reset too, because a reset or flush
    // must leave no stale op/arg bytes behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_OP;
            byte_idx <= '0;
            arg_idx  <= '0;
            op_q     <= '0;
            raw_q    <= '0;
        end else if (flush) begin
            state    <= S_OP;
            byte_idx <= '0;
            arg_idx  <= '0;
            op_q     <= '0;
            raw_q    <= '0;
        end else if (accept) begin
            case (state)
                S_OP: begin
                    op_q  <= OP_BITS'(in_data);
                    state <= S_ARG;
                end
                S_ARG: begin
                    raw_q[pos*BYTE_BITS +: BYTE_BITS] <= in_data;
                    if (byte_idx == BIDX_W'(BPA - 1)) begin
                        byte_idx <= '0;
                        if (arg_idx == AIDX_W'(NUM_ARGS - 1)) begin
                            arg_idx <= '0;
                            state   <= S_FLAGS;
                        end else begin
                            arg_idx <= arg_idx + 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                S_FLAGS: state <= S_OP;
                default: state <= S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (load && !op_ok && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    opcode_out_reg #(
        .WIDTH(WORD_BITS)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (word_w),
        .out_ready (out_ready),
        .can_load  (can_load),
        .out_data  (word_q),
        .out_valid (out_valid)
    );

    assign out_op    = word_q[OP_BITS-1:0];
    assign out_args  = word_q[OP_BITS +: ARGS_BITS];
    assign out_flags = word_q[WORD_BITS-1 -: FLAG_BITS];

endmodule
